// File: rtl/key_cmd_ctrl.sv
// Key-press command controller: turns debounced key pulses into register
// updates of a waveform generator and streams each change out as a config write.
module key_cmd_ctrl #(
    parameter logic [15:0] FREQ_STEP = 16'd100,
    parameter logic [15:0] FREQ_MIN  = 16'd1,
    parameter logic [15:0] FREQ_MAX  = 16'd50000,
    parameter logic [7:0]  AMP_STEP  = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] key_evt,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [1:0]  cfg_addr,
    output logic [15:0] cfg_data,
    output logic [1:0]  wave_sel,
    output logic [15:0] freq_word,
    output logic [7:0]  amp,
    output logic        run,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DEFLT  = 2'd3;

    localparam logic [3:0]  KEY_DEFLT = 4'd11;
    localparam logic [15:0] FREQ_RST  = 16'd1000;
    localparam logic [7:0]  AMP_RST   = 8'd128;

    logic [1:0]  state;
    logic [12:0] pending;
    logic [3:0]  key_idx;

    logic        grant_vld;
    logic [3:0]  grant_idx;
    logic [12:0] grant_mask;
    logic        accept;

    logic [1:0]  nxt_wave;
    logic [15:0] nxt_freq;
    logic [7:0]  nxt_amp;
    logic        nxt_run;
    logic [1:0]  upd_addr;
    logic [15:0] upd_data;
    logic        upd_changed;

    // Saturating arithmetic is done in a wider signed domain so neither
    // overflow past the top bound nor underflow below zero can wrap.
    function automatic logic [15:0] freq_inc(input logic [15:0] f);
        logic signed [17:0] s;
        s = $signed({2'b00, f}) + $signed({2'b00, FREQ_STEP});
        if (s > $signed({2'b00, FREQ_MAX})) return FREQ_MAX;
        return s[15:0];
    endfunction

    function automatic logic [15:0] freq_dec(input logic [15:0] f);
        logic signed [17:0] s;
        s = $signed({2'b00, f}) - $signed({2'b00, FREQ_STEP});
        if (s < $signed({2'b00, FREQ_MIN})) return FREQ_MIN;
        return s[15:0];
    endfunction

    function automatic logic [7:0] amp_inc(input logic [7:0] a);
        logic signed [9:0] s;
        s = $signed({2'b00, a}) + $signed({2'b00, AMP_STEP});
        if (s > 10'sd255) return 8'hFF;
        return s[7:0];
    endfunction

    function automatic logic [7:0] amp_dec(input logic [7:0] a);
        logic signed [9:0] s;
        s = $signed({2'b00, a}) - $signed({2'b00, AMP_STEP});
        if (s < 10'sd0) return 8'h00;
        return s[7:0];
    endfunction

    function automatic logic [15:0] reg_data(input logic [1:0]  addr,
                                             input logic [1:0]  w,
                                             input logic [15:0] f,
                                             input logic [7:0]  a,
                                             input logic        r);
        case (addr)
            2'd0:    return {14'd0, w};
            2'd1:    return f;
            2'd2:    return {8'd0, a};
            default: return {15'd0, r};
        endcase
    endfunction

    assign accept    = cfg_valid && cfg_ready;
    assign cfg_valid = (state == S_WRITE) || (state == S_DEFLT);
    assign busy      = (state != S_IDLE);

    // Lowest-index pending key wins; loop runs high-to-low so the last hit sticks.
    always_comb begin
        grant_idx = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (pending[i]) grant_idx = i[3:0];
        end
        grant_vld  = (state == S_IDLE) && (pending != 13'd0);
        grant_mask = grant_vld ? (13'd1 << grant_idx) : 13'd0;
    end

    always_comb begin
        nxt_wave = wave_sel;
        nxt_freq = freq_word;
        nxt_amp  = amp;
        nxt_run  = run;
        upd_addr = cfg_addr;
        case (key_idx)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                nxt_wave = key_idx[1:0];
                upd_addr = 2'd0;
            end
            4'd4: begin
                nxt_freq = freq_inc(freq_word);
                upd_addr = 2'd1;
            end
            4'd5: begin
                nxt_freq = freq_dec(freq_word);
                upd_addr = 2'd1;
            end
            4'd6: begin
                nxt_amp  = amp_inc(amp);
                upd_addr = 2'd2;
            end
            4'd7: begin
                nxt_amp  = amp_dec(amp);
                upd_addr = 2'd2;
            end
            4'd10: begin
                nxt_run  = ~run;
                upd_addr = 2'd3;
            end
            default: ;
        endcase
        upd_changed = (nxt_wave != wave_sel) || (nxt_freq != freq_word) ||
                      (nxt_amp != amp) || (nxt_run != run);
        upd_data    = reg_data(upd_addr, nxt_wave, nxt_freq, nxt_amp, nxt_run);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pending   <= 13'd0;
            key_idx   <= 4'd0;
            cfg_addr  <= 2'd0;
            cfg_data  <= 16'd0;
            wave_sel  <= 2'd0;
            freq_word <= FREQ_RST;
            amp       <= AMP_RST;
            run       <= 1'b0;
        end else begin
            // A pulse on a bit being granted this cycle re-arms it.
            pending <= (pending & ~grant_mask) | key_evt;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        if (grant_idx == KEY_DEFLT) begin
                            state     <= S_DEFLT;
                            wave_sel  <= 2'd0;
                            freq_word <= FREQ_RST;
                            amp       <= AMP_RST;
                            run       <= 1'b0;
                            cfg_addr  <= 2'd0;
                            cfg_data  <= 16'd0;
                        end else begin
                            state   <= S_UPDATE;
                            key_idx <= grant_idx;
                        end
                    end
                end
                S_UPDATE: begin
                    wave_sel  <= nxt_wave;
                    freq_word <= nxt_freq;
                    amp       <= nxt_amp;
                    run       <= nxt_run;
                    if (upd_changed) begin
                        state    <= S_WRITE;
                        cfg_addr <= upd_addr;
                        cfg_data <= upd_data;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (accept) state <= S_IDLE;
                end
                default: begin
                    // Default sweep: write addr 0..3 back-to-back, each held until taken.
                    if (accept) begin
                        if (cfg_addr == 2'd3) begin
                            state <= S_IDLE;
                        end else begin
                            cfg_addr <= cfg_addr + 2'd1;
                            cfg_data <= reg_data(cfg_addr + 2'd1, wave_sel, freq_word, amp, run);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl: expected config writes are queued as keys
// are pressed and a monitor checks every accepted write against the queue.
module tb_key_cmd_ctrl;

    typedef struct packed {
        logic [1:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] key_evt;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amp;
    logic        run;
    logic        busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    key_cmd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_evt   (key_evt),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .wave_sel  (wave_sel),
        .freq_word (freq_word),
        .amp       (amp),
        .run       (run),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] a, input logic [15:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    // Scoreboard monitor: every accepted write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0d, queue empty", cfg_addr, cfg_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cfg_addr !== e.a || cfg_data !== e.d) begin
                    n_err++;
                    $display("FAIL sb_write: got addr %0d data %0d, expected addr %0d data %0d",
                             cfg_addr, cfg_data, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [12:0] mask);
        @(posedge clk);
        #1 key_evt = mask;
        @(posedge clk);
        #1 key_evt = 13'd0;
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        bit done;
        quiet = 0;
        done  = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (busy === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_idle_timeout: busy still %0d, expected 0", name, busy);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (cfg_valid === 1'b1) seen = 1'b1;
        end
        check({name, "_valid_seen"}, seen, 1);
    endtask

    task automatic press_expect_none(input logic [12:0] mask, input string name);
        int seen;
        seen = 0;
        press(mask);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cfg_valid !== 1'b0) seen++;
        end
        check({name, "_no_write"}, seen, 0);
        wait_idle(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int a;
        int nv;
        int bad;
        logic [1:0]  a0;
        logic [15:0] d0;

        rst_n     = 1'b0;
        key_evt   = 13'd0;
        cfg_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", cfg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", cfg_addr, 0);
        check("rst_data", cfg_data, 0);
        check("rst_wave", wave_sel, 0);
        check("rst_freq", freq_word, 1000);
        check("rst_amp", amp, 128);
        check("rst_run", run, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Key 4 with exact latency: pending, UPDATE, then WRITE.
        sb.push_back(mk(2'd1, 16'd1100));
        @(posedge clk);
        #1 key_evt = 13'h0010;
        @(posedge clk);
        #1 key_evt = 13'd0;
        @(negedge clk);
        check("lat_n1_busy", busy, 0);
        @(negedge clk);
        check("lat_n2_busy", busy, 1);
        check("lat_n2_valid", cfg_valid, 0);
        @(negedge clk);
        check("lat_n3_valid", cfg_valid, 1);
        wait_idle("freq1");
        check("freq_1100", freq_word, 1100);
        check("busy_after", busy, 0);

        // Keys 2 and 6 together: lower index goes first.
        sb.push_back(mk(2'd0, 16'd2));
        sb.push_back(mk(2'd2, 16'd144));
        press(13'h0044);
        wait_idle("k2k6");
        check("wave_2", wave_sel, 2);
        check("amp_144", amp, 144);

        press_expect_none(13'h0004, "wave_same");
        press_expect_none(13'h1300, "keys_8_9_12");
        check("wave_kept", wave_sel, 2);

        // Frequency up to the top bound, then one press that saturates.
        f = 1100;
        for (int k = 0; k < 489; k++) begin
            nv = (f + 100 > 50000) ? 50000 : f + 100;
            sb.push_back(mk(2'd1, nv[15:0]));
            press(13'h0010);
            wait_idle("freq_up");
            f = nv;
        end
        check("freq_max", freq_word, 50000);
        press_expect_none(13'h0010, "freq_max_sat");
        check("freq_max_hold", freq_word, 50000);

        // Frequency down to the bottom bound without wrapping.
        for (int k = 0; k < 500; k++) begin
            nv = (f - 100 < 1) ? 1 : f - 100;
            sb.push_back(mk(2'd1, nv[15:0]));
            press(13'h0020);
            wait_idle("freq_dn");
            f = nv;
        end
        check("freq_min", freq_word, 1);
        press_expect_none(13'h0020, "freq_min_sat");

        // Amplitude up to 255 and down to 0.
        a = 144;
        for (int k = 0; k < 7; k++) begin
            nv = (a + 16 > 255) ? 255 : a + 16;
            sb.push_back(mk(2'd2, nv[15:0]));
            press(13'h0040);
            wait_idle("amp_up");
            a = nv;
        end
        check("amp_255", amp, 255);
        press_expect_none(13'h0040, "amp_max_sat");
        for (int k = 0; k < 16; k++) begin
            nv = (a - 16 < 0) ? 0 : a - 16;
            sb.push_back(mk(2'd2, nv[15:0]));
            press(13'h0080);
            wait_idle("amp_dn");
            a = nv;
        end
        check("amp_0", amp, 0);
        press_expect_none(13'h0080, "amp_min_sat");

        // Stalled write; two key-10 presses meanwhile merge into one toggle.
        #1 cfg_ready = 1'b0;
        sb.push_back(mk(2'd2, 16'd16));
        sb.push_back(mk(2'd3, 16'd1));
        press(13'h0040);
        wait_valid("stall");
        a0 = cfg_addr;
        d0 = cfg_data;
        check("stall_addr", a0, 2);
        check("stall_data", d0, 16);
        press(13'h0400);
        press(13'h0400);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cfg_valid !== 1'b1 || cfg_addr !== a0 || cfg_data !== d0) bad++;
        end
        check("stall_stable", bad, 0);
        @(posedge clk);
        #1 cfg_ready = 1'b1;
        wait_idle("stall");
        check("run_1", run, 1);
        check("amp_16", amp, 16);

        // Key 11 restores defaults and rewrites all four registers.
        sb.push_back(mk(2'd0, 16'd0));
        sb.push_back(mk(2'd1, 16'd1000));
        sb.push_back(mk(2'd2, 16'd128));
        sb.push_back(mk(2'd3, 16'd0));
        press(13'h0800);
        wait_idle("deflt");
        check("deflt_wave", wave_sel, 0);
        check("deflt_freq", freq_word, 1000);
        check("deflt_amp", amp, 128);
        check("deflt_run", run, 0);
        check("deflt_drained", sb.size(), 0);

        // Reset while a write is held: aborts at once and does not resume.
        #1 cfg_ready = 1'b0;
        press(13'h0400);
        wait_valid("rst_mid");
        check("rst_mid_run", run, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", cfg_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_run0", run, 0);
        check("rst_mid_freq", freq_word, 1000);
        check("rst_mid_amp", amp, 128);
        check("rst_mid_addr", cfg_addr, 0);
        check("rst_mid_data", cfg_data, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cfg_valid !== 1'b0) bad++;
        end
        check("rst_no_resume", bad, 0);
        check("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_cmd_ctrl.md
KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 Parameter FREQ_STEP, default 16'd100, frequency-word increment/decrement per key press.
REQ-002 Parameter FREQ_MIN, default 16'd1, lower saturation bound of freq_word.
REQ-003 Parameter FREQ_MAX, default 16'd50000, upper saturation bound of freq_word.
REQ-004 Parameter AMP_STEP, default 8'd16, amplitude increment/decrement per key press.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_evt  input  13  debounced key-press pulses, active high, one cycle per press.
REQ-008 cfg_valid  output  1  configuration write request to waveform datapath.
REQ-009 cfg_ready  input  1  datapath accepts write when high with cfg_valid.
REQ-010 cfg_addr  output  2  write address: 0 wave_sel, 1 freq_word, 2 amp, 3 run.
REQ-011 cfg_data  output  16  write data, zero-extended from the addressed register.
REQ-012 wave_sel  output  2  current waveform select.
REQ-013 freq_word  output  16  current frequency word.
REQ-014 amp  output  8  current amplitude.
REQ-015 run  output  1  generator run enable.
REQ-016 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-017 13-bit pending register: bit set on key_evt pulse, cleared when granted; same-cycle pulse and grant on one bit leaves bit set.
REQ-018 Arbitration: in IDLE with pending nonzero, lowest-index pending bit granted; one grant per pass through IDLE.
REQ-019 FSM states IDLE, UPDATE, WRITE, DEFLT; IDLE->UPDATE on grant; UPDATE->WRITE if value changed, else ->IDLE; WRITE->IDLE on cfg_valid&&cfg_ready; key 11 grant: IDLE->DEFLT.
REQ-020 Keys 0-3: wave_sel <= key index.
REQ-021 Key 4: freq_word <= min(freq_word+FREQ_STEP, FREQ_MAX), computed 17-bit, no wrap; key 5: freq_word <= max(freq_word-FREQ_STEP, FREQ_MIN), no underflow wrap.
REQ-022 Key 6: amp <= min(amp+AMP_STEP, 255), 9-bit compute; key 7: amp <= max(amp-AMP_STEP, 0).
REQ-023 Key 10: run <= ~run; keys 8, 9, 12: grant consumed, no register change, return to IDLE, no write.
REQ-024 Register update occurs in UPDATE; cfg_addr/cfg_data loaded same cycle with new value.
REQ-025 Unchanged value (same wave re-selected, saturation hit) SHALL issue no write.
REQ-026 cfg_valid high only in WRITE and DEFLT; cfg_addr/cfg_data stable while cfg_valid high and cfg_ready low.
REQ-027 DEFLT: registers loaded to reset values, then four writes addr 0,1,2,3 in order, each held until accepted; ->IDLE after addr 3 accepted; no pending grants during DEFLT.
REQ-028 key_evt pulses arriving while busy are captured in pending, never lost (repeat presses of one key before grant merge into one).
REQ-029 Latency: key_evt at cycle N in IDLE with pending empty -> cfg_valid at cycle N+3 (pending N+1, UPDATE N+2, WRITE N+3).
REQ-030 cfg_ready sampled only while cfg_valid high; cfg_ready with cfg_valid low ignored.

Reset
REQ-031 On rst_n low, asynchronously: FSM IDLE, pending 0, cfg_valid 0, cfg_addr 0, cfg_data 0, wave_sel 0, freq_word 16'd1000, amp 8'd128, run 0, busy 0.
REQ-032 Reset mid-write aborts transaction; cfg_valid drops immediately; no resumption after release.
REQ-033 First grant possible on second rising edge after rst_n deasserts.

Verification
REQ-034 Pulse key 4, cfg_ready=1 -> freq_word 1100, one write addr 1 data 1100, busy low after accept.
REQ-035 Pulse keys 2 and 6 same cycle -> write addr 0 data 2, then addr 2 data 144, in that order.
REQ-036 Freq_word 49950, key 4 twice -> 50000 written once; second press no cfg_valid.
REQ-037 cfg_ready low 10 cycles during write, key 10 pulsed meanwhile -> cfg_addr/data stable, then run toggle write follows acceptance.
REQ-038 After changes, key 11 -> four writes addr 0..3 data 0, 1000, 128, 0; outputs equal reset values.
REQ-039 rst_n asserted while cfg_valid high -> cfg_valid 0 same cycle, all outputs at REQ-031 values.
